// File: rtl/step_pulse_monitor.sv
// step_pulse_monitor: decodes a STEP/DIR stream into position, count, period and phase.
// Optional DIR setup check: define STEP_MONITOR_DIR_SETUP_CHECK_EN.
module step_pulse_monitor #(
    parameter int WIDTH     = 32,
    parameter int MIN_HIGH  = 2,
    parameter int DIR_SETUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             step,
    input  logic             dir,
    input  logic [WIDTH-1:0] min_period,
    input  logic [WIDTH-1:0] max_period,
    output logic [WIDTH-1:0] position,
    output logic [WIDTH-1:0] step_count,
    output logic [WIDTH-1:0] last_period,
    output logic             period_valid,
    output logic [1:0]       phase,
    output logic             overspeed,
    output logic             stall,
    output logic             dir_error
);
    localparam int              RW      = $clog2(MIN_HIGH + 1);
    localparam logic [RW-1:0]   RUN_MAX = RW'(MIN_HIGH);
    localparam logic [RW-1:0]   RUN_PRE = RW'(MIN_HIGH - 1);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    localparam logic [1:0] PH_IDLE   = 2'b00;
    localparam logic [1:0] PH_ACCEL  = 2'b01;
    localparam logic [1:0] PH_CRUISE = 2'b10;
    localparam logic [1:0] PH_DECEL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_RUN
    } state_t;

    state_t           state;
    logic [1:0]       step_sync;
    logic [1:0]       dir_sync;
    logic             step_s;
    logic             dir_s;
    logic [RW-1:0]    run_cnt;
    logic             qe;
    logic [WIDTH-1:0] pcnt;
    logic             timeout;
    logic [1:0]       run_phase;

    assign step_s  = step_sync[1];
    assign dir_s   = dir_sync[1];
    assign timeout = pcnt > max_period;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_sync <= '0;
            dir_sync  <= '0;
        end else begin
            step_sync <= {step_sync[0], step};
            dir_sync  <= {dir_sync[0], dir};
        end
    end

    // qe is registered: it fires in the single cycle the run count sits at MIN_HIGH
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
            qe      <= 1'b0;
        end else begin
            qe <= step_s && (run_cnt == RUN_PRE);
            if (!step_s)
                run_cnt <= '0;
            else if (run_cnt != RUN_MAX)
                run_cnt <= run_cnt + RW'(1);
        end
    end

    always_comb begin
        run_phase = PH_DECEL;
        unique case (1'b1)
            pcnt < last_period:  run_phase = PH_ACCEL;
            pcnt == last_period: run_phase = PH_CRUISE;
            default:             run_phase = PH_DECEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            position     <= '0;
            step_count   <= '0;
            last_period  <= '0;
            period_valid <= 1'b0;
            phase        <= PH_IDLE;
            overspeed    <= 1'b0;
            stall        <= 1'b0;
            pcnt         <= '0;
        end else begin
            period_valid <= 1'b0;
            stall        <= 1'b0;
            if (!enable) begin
                state <= S_IDLE;
                phase <= PH_IDLE;
            end else begin
                if (qe)
                    pcnt <= ONE;
                else if (pcnt <= max_period)
                    pcnt <= pcnt + ONE;
                if (qe) begin
                    step_count <= step_count + ONE;
                    position   <= position + (dir_s ? ONE : '1);
                end
                unique case (state)
                    S_IDLE: begin
                        if (qe)
                            state <= S_FIRST;
                    end
                    S_FIRST: begin
                        if (qe) begin
                            state        <= S_RUN;
                            last_period  <= pcnt;
                            period_valid <= 1'b1;
                            phase        <= PH_ACCEL;
                            if (pcnt < min_period)
                                overspeed <= 1'b1;
                        end else if (timeout) begin
                            state <= S_IDLE;
                        end
                    end
                    S_RUN: begin
                        if (qe) begin
                            last_period  <= pcnt;
                            period_valid <= 1'b1;
                            phase        <= run_phase;
                            if (pcnt < min_period)
                                overspeed <= 1'b1;
                        end else if (timeout) begin
                            state <= S_IDLE;
                            phase <= PH_IDLE;
                            stall <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
            if (clear) begin
                position   <= '0;
                step_count <= '0;
                overspeed  <= 1'b0;
            end
        end
    end

`ifdef STEP_MONITOR_DIR_SETUP_CHECK_EN
    localparam int            DW   = $clog2(DIR_SETUP + 1);
    localparam logic [DW-1:0] DSET = DW'(DIR_SETUP);

    logic          dir_d;
    logic [DW-1:0] dir_age;

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_d     <= 1'b0;
            dir_age   <= '0;
            dir_error <= 1'b0;
        end else begin
            dir_d <= dir_s;
            if (dir_s != dir_d)
                dir_age <= '0;
            else if (dir_age != DSET)
                dir_age <= dir_age + DW'(1);
            if (clear)
                dir_error <= 1'b0;
            else if (qe && enable && (dir_age < DSET))
                dir_error <= 1'b1;
        end
    end
`else
    logic unused_dir_setup;
    assign unused_dir_setup = ^DIR_SETUP;
    assign dir_error        = 1'b0;
`endif

endmodule

// File: tb/tb_step_pulse_monitor.sv
// tb_step_pulse_monitor: directed and randomized pulse trains for step_pulse_monitor,
// checked against an event-level model built from pulse rise times.
`timescale 1ns/1ps
module tb_step_pulse_monitor;
    localparam int W  = 32;
    localparam int MH = 2;
    localparam int DS = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         clear;
    logic         step;
    logic         dir;
    logic [W-1:0] min_period;
    logic [W-1:0] max_period;
    logic [W-1:0] position;
    logic [W-1:0] step_count;
    logic [W-1:0] last_period;
    logic         period_valid;
    logic [1:0]   phase;
    logic         overspeed;
    logic         stall;
    logic         dir_error;

    step_pulse_monitor #(
        .WIDTH(W),
        .MIN_HIGH(MH),
        .DIR_SETUP(DS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .clear(clear),
        .step(step),
        .dir(dir),
        .min_period(min_period),
        .max_period(max_period),
        .position(position),
        .step_count(step_count),
        .last_period(last_period),
        .period_valid(period_valid),
        .phase(phase),
        .overspeed(overspeed),
        .stall(stall),
        .dir_error(dir_error)
    );

    always #5 clk = ~clk;

    int edge_n     = 0;
    int pv_seen    = 0;
    int stall_seen = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        if (period_valid) pv_seen <= pv_seen + 1;
        if (stall) stall_seen <= stall_seen + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: state of the motion derived from qualified-edge times
    int   exp_count;
    int   exp_pos;
    int   exp_last;
    int   exp_prevp;
    int   exp_phase;
    int   exp_ovs;
    int   exp_derr;
    int   exp_pv    = 0;
    int   exp_stall = 0;
    int   seq_len;
    int   last_upd;
    int   cur_min;
    int   cur_max;

    function automatic void model_reset();
        exp_count = 0;
        exp_pos   = 0;
        exp_last  = 0;
        exp_prevp = 0;
        exp_phase = 0;
        exp_ovs   = 0;
        exp_derr  = 0;
        seq_len   = 0;
        last_upd  = 0;
    endfunction

    function automatic void model_clear();
        exp_count = 0;
        exp_pos   = 0;
        exp_ovs   = 0;
        exp_derr  = 0;
    endfunction

    // motion ends once max_period+1 edges pass after the last update
    function automatic void model_settle(int t);
        if (seq_len > 0 && t >= last_upd + cur_max + 1) begin
            if (seq_len >= 2) exp_stall++;
            seq_len   = 0;
            exp_phase = 0;
        end
    endfunction

    function automatic void model_step(int rise, bit d);
        int upd;
        int p;
        upd = rise + MH + 3;
        model_settle(upd - 1);
        exp_count++;
        exp_pos += d ? 1 : -1;
        if (seq_len > 0) begin
            p = upd - last_upd;
            exp_pv++;
            exp_last = p;
            if (p < cur_min) exp_ovs = 1;
            if (seq_len == 1) exp_phase = 1;
            else if (p < exp_prevp) exp_phase = 1;
            else if (p == exp_prevp) exp_phase = 2;
            else exp_phase = 3;
            exp_prevp = p;
        end
        seq_len++;
        last_upd = upd;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp_v);
        n_chk++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag);
        @(negedge clk);
        #1;
        model_settle(edge_n);
        chk({tag, ".count"}, step_count, W'(exp_count));
        chk({tag, ".pos"}, position, W'(exp_pos));
        chk({tag, ".last"}, last_period, W'(exp_last));
        chk({tag, ".phase"}, W'(phase), W'(exp_phase));
        chk({tag, ".ovs"}, W'(overspeed), W'(exp_ovs));
        chk({tag, ".pv"}, W'(pv_seen), W'(exp_pv));
        chk({tag, ".stall"}, W'(stall_seen), W'(exp_stall));
        chk({tag, ".derr"}, W'(dir_error), W'(exp_derr));
    endtask

    task automatic send(input int lo, input int hi, input bit d);
        int r;
        dir = d;
        tick(lo);
        r    = edge_n;
        step = 1'b1;
        tick(hi);
        step = 1'b0;
        tick(3);
        if (hi >= MH && enable) model_step(r, d);
    endtask

    task automatic set_periods(input int mn, input int mx);
        min_period = W'(mn);
        max_period = W'(mx);
        cur_min    = mn;
        cur_max    = mx;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        model_clear();
    endtask

    int trap_p[7]  = '{100, 90, 80, 80, 80, 90, 100};
    int trap_ph[6] = '{1, 1, 2, 2, 3, 3};

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        clear  = 1'b0;
        step   = 1'b0;
        dir    = 1'b0;
        set_periods(20, 150);
        model_reset();
        tick(3);
        reset = 1'b0;
        tick(1);
        check_all("reset");

        send(trap_p[0] - 6, 3, 1'b1);
        for (int i = 1; i < 7; i++) begin
            send(trap_p[i] - 6, 3, 1'b1);
            check_all("trap");
            chk("trap.per", last_period, W'(trap_p[i]));
            chk("trap.ph", W'(phase), W'(trap_ph[i-1]));
        end
        chk("trap.pos7", position, W'(7));
        chk("trap.ovs0", W'(overspeed), W'(0));
        tick(200);
        check_all("trap.end");

        do_clear();
        for (int i = 0; i < 5; i++) send(30, 3, 1'b1);
        for (int i = 0; i < 8; i++) send(30, 3, 1'b0);
        check_all("rev");
        chk("rev.pos", position, W'(-3));
        chk("rev.cnt", step_count, W'(13));
        tick(200);

        do_clear();
        for (int i = 0; i < 5; i++) send(20, (i % 2 == 0) ? 3 : 1, 1'b1);
        check_all("glitch");
        chk("glitch.cnt", step_count, W'(3));
        tick(200);

        do_clear();
        send(50, 3, 1'b1);
        send(24, 3, 1'b1);
        check_all("ovs.30");
        send(9, 3, 1'b1);
        check_all("ovs.15");
        chk("ovs.set", W'(overspeed), W'(1));
        tick(160);
        check_all("stall");
        chk("stall.ph", W'(phase), W'(0));

        send(20, 3, 1'b1);
        send(145, 3, 1'b1);
        check_all("bnd.151");
        chk("bnd.per", last_period, W'(151));
        send(146, 3, 1'b1);
        check_all("bnd.152");

        send(20, 3, 1'b1);
        enable = 1'b0;
        tick(2);
        seq_len   = 0;
        exp_phase = 0;
        check_all("dis");
        send(20, 3, 1'b1);
        step = 1'b1;
        tick(8);
        enable = 1'b1;
        tick(4);
        step = 1'b0;
        tick(4);
        check_all("reen");
        send(20, 3, 1'b1);
        send(20, 3, 1'b1);
        check_all("reen.run");
        chk("reen.per", last_period, W'(26));

        do_clear();
        check_all("clr");
        send(20, 3, 1'b1);
        check_all("clr.next");
        chk("clr.per", last_period, W'(27));
        chk("clr.cnt", step_count, W'(1));
        tick(200);

        set_periods(20, 0);
        send(20, 3, 1'b1);
        send(20, 3, 1'b1);
        check_all("max0");
        set_periods(0, 150);
        tick(5);
        for (int i = 0; i < 3; i++) send(10, 3, 1'b0);
        check_all("min0");
        chk("min0.ovs", W'(overspeed), W'(0));
        tick(200);

        set_periods(20, 150);
        for (int i = 0; i < 40; i++) begin
            send($urandom_range(10, 170), $urandom_range(1, 4),
                 1'($urandom_range(0, 1)));
            check_all("rnd");
        end
        tick(200);

`ifdef STEP_MONITOR_DIR_SETUP_CHECK_EN
        begin
            int r;
            dir = 1'b0;
            tick(20);
            r    = edge_n;
            step = 1'b1;
            tick(1);
            dir = 1'b1;
            tick(2);
            step = 1'b0;
            tick(3);
            model_step(r, 1'b1);
            exp_derr = 1;
            check_all("dset");
            chk("dset.err", W'(dir_error), W'(1));
            tick(200);
        end
`endif

        check_all("pre.rst");
        step = 1'b1;
        tick(2);
        reset = 1'b1;
        step  = 1'b0;
        tick(1);
        reset = 1'b0;
        model_reset();
        check_all("rst.mid");
        tick(10);
        check_all("rst.after");
        chk("rst.cnt", step_count, W'(0));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
